tlul_dccm_ctrl: RTL and testbench

// - Parametrised TL-UL data-memory (DCCM) slave: owns byte-writable storage, its own TL-UL front end, response FIFO.
// - Next-generation DCCM: configurable depth/outstanding, true per-byte writes from a_mask, request checking, optional parity.
// - Sits on the TL-UL crossbar as a device port; one request accepted per cycle, responses returned in order.

---
 rtl/tlul_dccm_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_tlul_dccm_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_dccm_ctrl.sv
// tlul_dccm_ctrl: TL-UL device-port data memory (DCCM) with byte-lane writes,
// request legality checking, a one-stage read pipeline and an in-order
// response FIFO. The A-channel credit count is kept in a register so a_ready
// never depends combinationally on d_ready.
//
// Build option: define TLUL_DCCM_PARITY_EN to store one even-parity bit per
// byte (36-bit words) and flag read parity mismatches. Undefined: 32-bit
// words, no checking, parity_err_o tied low.

package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_dccm_ctrl #(
    parameter int MemDepth    = 1024,
    parameter int Outstanding = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    output logic               parity_err_o
);

    import tlul_pkg::*;

    localparam int AddrW = $clog2(MemDepth);
    localparam int CntW  = $clog2(Outstanding + 1);
    localparam int PtrW  = $clog2(Outstanding);
`ifdef TLUL_DCCM_PARITY_EN
    localparam int MemW  = 36;
`else
    localparam int MemW  = 32;
`endif

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic [31:0] data;
    } resp_t;

    // ------------------------------------------------------------------
    // Request decode and legality check
    // ------------------------------------------------------------------
    logic [AddrW-1:0] req_idx;
    logic [3:0]       req_lanes;
    logic             req_is_put;
    logic             req_is_get;
    logic             req_err;
    logic             accept;
    logic             a_ready;
    logic             d_valid;
    logic             pop;
    logic [CntW-1:0]  pend_q;

    // Address bits above the word index belong to the crossbar decode.
    logic unused_bits;
    assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:AddrW+2]};

    assign a_ready = rst_ni && (pend_q < CntW'(Outstanding));
    assign accept  = tl_i.a_valid && a_ready;

    // Decode lanes touched by the request and flag every illegal form.
    always_comb begin
        logic op_ok;
        logic align_ok;
        logic range_ok;
        logic mask_ok;
        req_idx    = tl_i.a_address[AddrW+1:2];
        req_is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        req_is_get = (tl_i.a_opcode == Get);
        op_ok      = req_is_put || req_is_get;
        case (tl_i.a_size)
            2'd0:    req_lanes = 4'b0001 << tl_i.a_address[1:0];
            2'd1:    req_lanes = 4'b0011 << tl_i.a_address[1:0];
            default: req_lanes = 4'b1111;
        endcase
        case (tl_i.a_size)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = (tl_i.a_address[0] == 1'b0);
            2'd2:    align_ok = (tl_i.a_address[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        range_ok = ({1'b0, req_idx} < (AddrW+1)'(MemDepth));
        mask_ok  = 1'b1;
        if (req_is_put && ((tl_i.a_mask & ~req_lanes) != 4'b0000)) begin
            mask_ok = 1'b0;
        end
        if ((tl_i.a_opcode == PutFullData) && (tl_i.a_mask != req_lanes)) begin
            mask_ok = 1'b0;
        end
        req_err = !(op_ok && align_ok && range_ok && mask_ok);
    end

    // ------------------------------------------------------------------
    // Storage: writes and reads both commit on the accept edge, so a read
    // accepted the cycle after a write already sees the new data.
    // ------------------------------------------------------------------
    logic [MemW-1:0] mem [MemDepth];
    logic [MemW-1:0] s1_rdata_q;

    // Byte-lane write or word read on the accept edge; storage survives reset.
    always_ff @(posedge clk_i) begin
        if (accept && !req_err) begin
            if (req_is_put) begin
                for (int i = 0; i < 4; i++) begin
                    if (tl_i.a_mask[i]) begin
                        mem[req_idx][8*i +: 8] <= tl_i.a_data[8*i +: 8];
`ifdef TLUL_DCCM_PARITY_EN
                        mem[req_idx][32+i]     <= ^tl_i.a_data[8*i +: 8];
`endif
                    end
                end
            end else begin
                s1_rdata_q <= mem[req_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: response info alongside the read word
    // ------------------------------------------------------------------
    logic       s1_valid_q;
    logic       s1_get_q;
    logic       s1_err_q;
    logic [1:0] s1_size_q;
    logic [7:0] s1_source_q;

    // Capture response attributes of the accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_get_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_size_q   <= 2'd0;
            s1_source_q <= 8'd0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_get_q    <= req_is_get;
                s1_err_q    <= req_err;
                s1_size_q   <= tl_i.a_size;
                s1_source_q <= tl_i.a_source;
            end
        end
    end

    logic  par_err;
    resp_t s1_resp;

`ifdef TLUL_DCCM_PARITY_EN
    // Even parity per byte: a clean byte plus its parity bit XORs to zero.
    always_comb begin
        logic [3:0] par_bad;
        for (int i = 0; i < 4; i++) begin
            par_bad[i] = ^{s1_rdata_q[32+i], s1_rdata_q[8*i +: 8]};
        end
        par_err = s1_valid_q && s1_get_q && !s1_err_q && (par_bad != 4'b0000);
    end
`else
    assign par_err = 1'b0;
`endif

    assign parity_err_o = par_err;

    // Build the FIFO entry; a parity error still returns the read data.
    always_comb begin
        s1_resp        = '0;
        s1_resp.opcode = s1_get_q ? AccessAckData : AccessAck;
        s1_resp.size   = s1_size_q;
        s1_resp.source = s1_source_q;
        s1_resp.error  = s1_err_q || par_err;
        s1_resp.data   = (s1_get_q && !s1_err_q) ? s1_rdata_q[31:0] : 32'h0;
    end

    // ------------------------------------------------------------------
    // Response FIFO. Depth equals the credit limit, so it cannot overflow.
    // ------------------------------------------------------------------
    resp_t           fifo_q [Outstanding];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] fcnt_q;
    logic            push;
    resp_t           head;

    assign push    = s1_valid_q;
    assign d_valid = (fcnt_q != '0);
    assign pop     = d_valid && tl_i.d_ready;
    assign head    = fifo_q[rptr_q];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Outstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // FIFO payload write; contents need no reset since fcnt_q gates d_valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= s1_resp;
        end
    end

    // FIFO pointers/occupancy and the pending credit count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
            pend_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + CntW'(1);
                2'b01:   fcnt_q <= fcnt_q - CntW'(1);
                default: fcnt_q <= fcnt_q;
            endcase
            case ({accept, pop})
                2'b10:   pend_q <= pend_q + CntW'(1);
                2'b01:   pend_q <= pend_q - CntW'(1);
                default: pend_q <= pend_q;
            endcase
        end
    end

    // D channel driven from the FIFO head; unused fields stay zero.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_valid = d_valid;
        if (d_valid) begin
            tl_o.d_opcode = head.opcode;
            tl_o.d_size   = head.size;
            tl_o.d_source = head.source;
            tl_o.d_error  = head.error;
            tl_o.d_data   = head.data;
        end
    end

endmodule

// File: tb/tb_tlul_dccm_ctrl.sv
// Scoreboard bench for tlul_dccm_ctrl (MemDepth=1000, Outstanding=2).
// The reference model keeps a word array plus a per-word mask of bytes with
// corrupted parity, and derives each expected response from the TL-UL rules.
`timescale 1ns/1ps
module tb_tlul_dccm_ctrl;

    localparam int DEPTH = 1000;
    localparam int OUTS  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;

    tlul_pkg::tl_h2d_t tl_i;
    tlul_pkg::tl_d2h_t tl_o;
    logic              parity_err;

    always_comb begin
        tl_i           = '0;
        tl_i.a_valid   = a_valid;
        tl_i.a_opcode  = a_opcode;
        tl_i.a_size    = a_size;
        tl_i.a_source  = a_source;
        tl_i.a_address = a_address;
        tl_i.a_mask    = a_mask;
        tl_i.a_data    = a_data;
        tl_i.d_ready   = d_ready;
    end

    tlul_dccm_ctrl #(.MemDepth(DEPTH), .Outstanding(OUTS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .parity_err_o(parity_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic        err;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mm  [DEPTH];
    logic [3:0]  bad [DEPTH];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_pop = -100;
    bit head_seen = 1'b0;
    int par_pulses = 0;
    int par_expect = 0;
    bit rand_rdy = 1'b0;
    logic rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: decide legality, apply writes, build the response.
    task automatic model_accept(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                                input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        exp_t e;
        int idx;
        logic [3:0] lanes;
        bit err;
        bit put;
        idx = int'((addr >> 2) & 32'h3FF);
        put = (op == 3'd0) || (op == 3'd1);
        case (sz)
            2'd0:    lanes = 4'b0001 << addr[1:0];
            2'd1:    lanes = 4'b0011 << addr[1:0];
            default: lanes = 4'b1111;
        endcase
        err = 1'b0;
        if (!(put || op == 3'd4)) err = 1'b1;
        if (sz > 2'd2) err = 1'b1;
        if ((addr & ((32'd1 << sz) - 32'd1)) != 32'd0) err = 1'b1;
        if (idx >= DEPTH) err = 1'b1;
        if (put && ((mask & ~lanes) != 4'b0000)) err = 1'b1;
        if (op == 3'd0 && mask != lanes) err = 1'b1;
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = sz;
        e.src  = src;
        e.err  = err;
        e.data = 32'h0;
        e.acc  = cyc;
        if (!err) begin
            if (op == 3'd4) begin
                e.data = mm[idx];
`ifdef TLUL_DCCM_PARITY_EN
                if (bad[idx] != 4'b0000) begin
                    e.err = 1'b1;
                    par_expect++;
                end
`endif
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (mask[i]) begin
                        mm[idx][8*i +: 8] = data[8*i +: 8];
                        bad[idx][i] = 1'b0;
                    end
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                        output int waited);
        waited = 0;
        @(negedge clk);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr;
        a_mask = mask; a_data = data; a_source = src;
        #1;
        while (!tl_o.a_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!tl_o.a_ready) begin
            errors++;
            $display("FAIL accept_timeout: a_ready stuck low for src %0h", src);
        end else begin
            model_accept(op, sz, addr, mask, data, src);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
            sb.delete();
        end
    endtask

    // d_ready driver: random or forced.
    initial begin
        d_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            d_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: exact arrival cycle of each head, then field compare on pop.
    initial begin
        int exp_cyc;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (parity_err) par_pulses++;
                if (tl_o.d_valid) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_d_valid: src %0h with nothing expected", tl_o.d_source);
                    end else begin
                        if (!head_seen) begin
                            exp_cyc = (sb[0].acc + 2 > prev_pop + 1) ? sb[0].acc + 2 : prev_pop + 1;
                            chk("latency", cyc, exp_cyc);
                            head_seen = 1'b1;
                        end
                        if (d_ready) begin
                            chk("d_opcode", {29'd0, tl_o.d_opcode}, {29'd0, sb[0].op});
                            chk("d_size",   {30'd0, tl_o.d_size},   {30'd0, sb[0].size});
                            chk("d_source", {24'd0, tl_o.d_source}, {24'd0, sb[0].src});
                            chk("d_error",  {31'd0, tl_o.d_error},  {31'd0, sb[0].err});
                            chk("d_data",   tl_o.d_data,            sb[0].data);
                            chk("d_param_sink", {28'd0, tl_o.d_param, tl_o.d_sink}, 32'd0);
                            void'(sb.pop_front());
                            prev_pop = cyc;
                            head_seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int w;
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  lanes;
        logic [3:0]  mask;
        int idx;
        int off;
        for (int i = 0; i < DEPTH; i++) bad[i] = 4'b0000;

        // Reset with a request pending on the A channel.
        rst_n = 1'b0;
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2; a_address = 32'h10;
        a_mask = 4'hF; a_data = 32'h0; a_source = 8'h1;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        chk("rst_d_valid", {31'd0, tl_o.d_valid}, 32'd0);
        chk("rst_parity", {31'd0, parity_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", {31'd0, tl_o.a_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("post_rst_d_valid", {31'd0, tl_o.d_valid}, 32'd0);

        // Preload every word so the model knows all storage contents.
        rand_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send(3'd0, 2'd2, 32'(i * 4), 4'hF, $urandom, 8'(i), w);
        end
        idle();
        drain();

        // Directed write/read, partial write and RAW with d_ready held high.
        rand_rdy = 1'b0; rdy_force = 1'b1;
        repeat (2) @(negedge clk);
        send(3'd0, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, w);
        idle();
        drain();
        send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd5, w);
        idle();
        drain();
        send(3'd1, 2'd1, 32'h12, 4'hC, 32'h12340000, 8'd6, w);
        send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd7, w);
        idle();
        drain();

        // Illegal requests, then a clean read of the same word.
        send(3'd4, 2'd2, 32'h11, 4'h0, 32'h0, 8'd8, w);
        send(3'd3, 2'd2, 32'h20, 4'hF, 32'h55AA55AA, 8'd9, w);
        send(3'd4, 2'd2, 32'(DEPTH * 4), 4'h0, 32'h0, 8'd10, w);
        send(3'd0, 2'd2, 32'h20, 4'h3, 32'h11111111, 8'd11, w);
        send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd12, w);
        idle();
        drain();

        // Credit limit: two Gets fill the pipe, the third waits for d_ready.
        rdy_force = 1'b0;
        repeat (2) @(negedge clk);
        send(3'd4, 2'd2, 32'h40, 4'h0, 32'h0, 8'd21, w);
        send(3'd4, 2'd2, 32'h44, 4'h0, 32'h0, 8'd22, w);
        chk("bp_second_no_wait", 32'(w), 32'd0);
        @(negedge clk);
        a_opcode = 3'd4; a_address = 32'h48; a_source = 8'd23;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_a_ready_low", {31'd0, tl_o.a_ready}, 32'd0);
            @(negedge clk);
        end
        a_valid = 1'b0;
        rdy_force = 1'b1;
        send(3'd4, 2'd2, 32'h48, 4'h0, 32'h0, 8'd23, w);
        idle();
        drain();

        // Reset while responses are queued: they must vanish, storage stays.
        rdy_force = 1'b0;
        repeat (2) @(negedge clk);
        send(3'd4, 2'd2, 32'h50, 4'h0, 32'h0, 8'd31, w);
        send(3'd4, 2'd2, 32'h54, 4'h0, 32'h0, 8'd32, w);
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        prev_pop = -100;
        #1;
        chk("midrst_d_valid", {31'd0, tl_o.d_valid}, 32'd0);
        chk("midrst_a_ready", {31'd0, tl_o.a_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        repeat (6) @(negedge clk);
        send(3'd4, 2'd2, 32'h10, 4'h0, 32'h0, 8'd33, w);
        idle();
        drain();

        // Corrupt one stored bit and read it back, then repair by rewrite.
        @(negedge clk);
        dut.mem[16][5] = ~dut.mem[16][5];
        mm[16][5] = ~mm[16][5];
        bad[16][0] = 1'b1;
        send(3'd4, 2'd2, 32'h40, 4'h0, 32'h0, 8'h41, w);
        idle();
        drain();
        send(3'd0, 2'd2, 32'h40, 4'hF, 32'hA5A5C3C3, 8'h42, w);
        send(3'd4, 2'd2, 32'h40, 4'h0, 32'h0, 8'h43, w);
        idle();
        drain();

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5:       op = 3'd0;
                6, 7, 8, 9, 10, 11:     op = 3'd1;
                12, 13, 14, 15, 16, 17: op = 3'd4;
                default: begin
                    op = 3'($urandom_range(2, 7));
                    if (op == 3'd4) op = 3'd3;
                end
            endcase
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 15);
            if (sz <= 2'd2 && $urandom_range(0, 7) != 0) off = $urandom_range(0, 3) & ~((1 << sz) - 1);
            else off = $urandom_range(0, 3);
            addr = (($urandom & 32'hFFFFF) << 12) | 32'(idx << 2) | 32'(off);
            case (sz)
                2'd0:    lanes = 4'b0001 << off;
                2'd1:    lanes = 4'b0011 << off;
                default: lanes = 4'b1111;
            endcase
            if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
            else if (op == 3'd1) mask = lanes & 4'($urandom);
            else mask = lanes;
            send(op, sz, addr, mask, $urandom, 8'($urandom), w);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();
        drain();

        chk("parity_pulses", 32'(par_pulses), 32'(par_expect));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
